// File: rtl/serial_mag_comp.sv
// Bit-serial N-bit unsigned magnitude comparator: walks captured operands MSB-first,
// one bit per clock, and stops at the first differing bit with one-hot result flags.
module serial_mag_comp #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         a_eq_b,
    output logic         a_lt_b,
    output logic         a_gt_b,
    output logic [1:0]   dbg_state
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Handshake: start is taken on any rising edge where start=1 and busy=0;
    // a and b are captured only on that edge, and done marks the single cycle
    // in which the flags first become valid (they then hold until the next start).
    state_t        state_q;
    logic [N-1:0]  sa_q, sb_q;
    logic [N-1:0]  sa_d, sb_d;
    logic [CW-1:0] cnt_q;
    logic          busy_q, done_q, eq_q, lt_q, gt_q;

    assign sa_d = sa_q << 1;
    assign sb_d = sb_q << 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        cnt_q   <= CW'(N - 1);
                        eq_q    <= 1'b0;
                        lt_q    <= 1'b0;
                        gt_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                SCAN: begin
                    if (sa_q[N-1] != sb_q[N-1]) begin
                        // The first differing bit alone decides the ordering.
                        gt_q    <= sa_q[N-1];
                        lt_q    <= sb_q[N-1];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (cnt_q == '0) begin
                        eq_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        sa_q  <= sa_d;
                        sb_q  <= sb_d;
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign a_eq_b    = eq_q;
    assign a_lt_b    = lt_q;
    assign a_gt_b    = gt_q;
    assign dbg_state = state_q;

endmodule
